// File: rtl/synth_pkg.sv
// Shared types, constants and helpers for the polyphonic additive synthesizer.
package synth_pkg;

    // Largest harmonic count the issue logic and shift table support.
    localparam int MAX_HARM = 8;

    // Per-harmonic attenuation as an arithmetic right shift, indexed by h-1.
    localparam int HARM_SHIFT [MAX_HARM] = '{0, 1, 2, 2, 3, 3, 4, 4};

    // Working width of the saturation helper; wide enough for any accumulator.
    localparam int SAT_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        PHASE,
        RUN,
        DRAIN,
        OUT
    } state_t;

    // Clamp a signed value into the signed range of 'width' bits and report clipping.
    function automatic logic signed [SAT_W-1:0] saturate(
        input  logic signed [SAT_W-1:0] value,
        input  int                      width,
        output logic                    clipped
    );
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        max_v   = (SAT_W'(1) <<< (width - 1)) - SAT_W'(1);
        min_v   = -max_v - SAT_W'(1);
        clipped = 1'b0;
        saturate = value;
        if (value > max_v) begin
            saturate = max_v;
            clipped  = 1'b1;
        end else if (value < min_v) begin
            saturate = min_v;
            clipped  = 1'b1;
        end
    endfunction

endpackage

// File: rtl/sine_lut.sv
// Full-wave signed sine ROM with a registered read port.
// entry[i] = round((2^(DATA_W-1)-1) * sin(2*pi*i / 2^ADDR_W)), built at elaboration.
module sine_lut #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic                     clk,
    input  logic [ADDR_W-1:0]        addr,
    output logic signed [DATA_W-1:0] data
);

    localparam int  DEPTH = 2 ** ADDR_W;
    localparam real PI    = 3.14159265358979323846;

    typedef logic [DEPTH*DATA_W-1:0] rom_t;

    // Round half away from zero so the table stays odd-symmetric around zero.
    function automatic rom_t build_rom();
        rom_t   rom;
        real    amp;
        real    x;
        integer v;
        rom = '0;
        amp = real'((2 ** (DATA_W - 1)) - 1);
        for (int i = 0; i < DEPTH; i++) begin
            x = amp * $sin(2.0 * PI * real'(i) / real'(DEPTH));
            v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
            rom[i*DATA_W +: DATA_W] = DATA_W'(v);
        end
        return rom;
    endfunction

    localparam rom_t ROM = build_rom();

    // Registered ROM read: data follows addr one clock later.
    // NOTE: the read register has no reset; it is a don't-care until an address is issued, and a separate valid bit gates its use.
    always_ff @(posedge clk) begin
        data <= ROM[int'(addr) * DATA_W +: DATA_W];
    end

endmodule

// File: rtl/poly_additive_synth.sv
// Polyphonic additive synthesizer: one phase accumulator per voice, harmonics
// derived by multiplying the phase, one shared sine LUT time-multiplexed over
// every (voice, harmonic) pair, weighted accumulation, and a saturated output.
module poly_additive_synth
    import synth_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int NUM_HARM   = 6,   // at most MAX_HARM
    parameter int PHASE_W    = 24,
    parameter int DATA_W     = 16,
    parameter int LUT_ADDR_W = 8
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic                            CS,
    input  logic                            sample_clk,
    input  logic [NUM_VOICES*PHASE_W-1:0]   freq_in,
    input  logic [NUM_VOICES-1:0]           note_on,
    output logic signed [DATA_W-1:0]        data_out,
    output logic                            data_valid,
    output logic                            sat_flag,
    output logic                            overrun
);

    localparam int PAIRS   = NUM_VOICES * NUM_HARM;
    localparam int ACC_W   = DATA_W + $clog2(PAIRS);
    localparam int VOICE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t                   state;
    logic                     sample_clk_q;
    logic                     tick;
    logic [PHASE_W-1:0]       phase [NUM_VOICES];

    // Issue stage: current (voice, harmonic) pair.
    logic [VOICE_W-1:0]       voice_idx;
    logic [2:0]               harm_idx;
    logic                     last_pair;
    logic                     drain_cnt;
    logic [PHASE_W-1:0]       phase_sel;
    logic [3:0]               harm_mult;
    logic [LUT_ADDR_W-1:0]    lut_addr;

    // LUT stage: sidebands travelling alongside the registered ROM read.
    logic signed [DATA_W-1:0] lut_data;
    logic                     p1_valid;
    logic                     p1_gate;
    logic [2:0]               p1_shift;

    // Accumulate stage.
    logic signed [DATA_W-1:0] lut_scaled;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] sat_sample;
    logic                     sat_clip;

    assign tick      = sample_clk & ~sample_clk_q;
    assign last_pair = (voice_idx == VOICE_W'(NUM_VOICES - 1)) &&
                       (harm_idx  == 3'(NUM_HARM - 1));

    // Edge detector for the sample-rate strobe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sample_clk_q <= 1'b0;
        end else begin
            sample_clk_q <= sample_clk;
        end
    end

    // Issue address: top bits of (phase_v * h) mod 2^PHASE_W.
    // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        phase_sel = phase[voice_idx];
        harm_mult = {1'b0, harm_idx} + 4'd1;
        lut_addr  = LUT_ADDR_W'((phase_sel * PHASE_W'(harm_mult)) >> (PHASE_W - LUT_ADDR_W));
    end

    sine_lut #(
        .DATA_W (DATA_W),
        .ADDR_W (LUT_ADDR_W)
    ) u_sine_lut (
        .clk  (Clk),
        .addr (lut_addr),
        .data (lut_data)
    );

    // Harmonic weighting, voice gating and output saturation.
    always_comb begin
        lut_scaled = lut_data >>> p1_shift;
        term       = p1_gate ? ACC_W'(lut_scaled) : '0;
        sat_sample = DATA_W'(saturate(SAT_W'(acc), DATA_W, sat_clip));
    end

    // Frame sequencer, phase accumulators, pipeline and registered outputs.
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            voice_idx  <= '0;
            harm_idx   <= '0;
            drain_cnt  <= 1'b0;
            p1_valid   <= 1'b0;
            p1_gate    <= 1'b0;
            p1_shift   <= '0;
            acc        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sat_flag   <= 1'b0;
            overrun    <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= '0;
            end
        end else begin
            data_valid <= 1'b0;

            // A tick mid-frame is dropped; the running frame completes untouched.
            if (tick && CS && (state != IDLE)) begin
                overrun <= 1'b1;
            end

            // note_on and the shift are captured at issue time, aligned with the ROM read.
            p1_valid <= (state == RUN);
            p1_gate  <= note_on[voice_idx];
            p1_shift <= 3'(HARM_SHIFT[harm_idx]);

            if (p1_valid) begin
                acc <= acc + term;
            end

            case (state)
                IDLE: begin
                    if (tick && CS) begin
                        state <= PHASE;
                    end
                end
                PHASE: begin
                    // Released voices restart from phase 0 on their next note.
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        phase[v] <= note_on[v] ? phase[v] + freq_in[v*PHASE_W +: PHASE_W] : '0;
                    end
                    acc       <= '0;
                    voice_idx <= '0;
                    harm_idx  <= '0;
                    state     <= RUN;
                end
                RUN: begin
                    if (last_pair) begin
                        drain_cnt <= 1'b0;
                        state     <= DRAIN;
                    end else if (harm_idx == 3'(NUM_HARM - 1)) begin
                        harm_idx  <= '0;
                        voice_idx <= voice_idx + 1'b1;
                    end else begin
                        harm_idx  <= harm_idx + 3'd1;
                    end
                end
                DRAIN: begin
                    // Two cycles: the last pair leaves the ROM, then lands in acc.
                    if (drain_cnt) begin
                        state <= OUT;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                OUT: begin
                    data_out   <= sat_sample;
                    data_valid <= 1'b1;
                    if (sat_clip) begin
                        sat_flag <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_additive_synth.sv
// Directed self-checking bench for poly_additive_synth (default parameters).
module tb_poly_additive_synth;

    localparam int NV      = 4;
    localparam int PW      = 24;
    localparam int DW      = 16;
    localparam int LATENCY = 28;
    localparam int NVEC    = 8;

    logic                   Clk = 1'b0;
    logic                   Reset;
    logic                   CS;
    logic                   sample_clk;
    logic [NV*PW-1:0]       freq_in;
    logic [NV-1:0]          note_on;
    logic signed [DW-1:0]   data_out;
    logic                   data_valid;
    logic                   sat_flag;
    logic                   overrun;

    int total    = 0;
    int passed   = 0;
    int dv_count = 0;

    typedef struct {
        logic [PW-1:0] f0;
        logic [PW-1:0] f1;
        logic [PW-1:0] f2;
        logic [PW-1:0] f3;
        logic [NV-1:0] note;
        int            exp_out;
        logic          exp_sat;
    } vec_t;

    vec_t vecs [NVEC];

    poly_additive_synth dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CS         (CS),
        .sample_clk (sample_clk),
        .freq_in    (freq_in),
        .note_on    (note_on),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sat_flag   (sat_flag),
        .overrun    (overrun)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (data_valid === 1'b1) dv_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset      = 1'b1;
        sample_clk = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic set_voices(input logic [PW-1:0] f0, input logic [PW-1:0] f1,
                              input logic [PW-1:0] f2, input logic [PW-1:0] f3,
                              input logic [NV-1:0] n);
        freq_in = {f3, f2, f1, f0};
        note_on = n;
    endtask

    // One tick, then wait (bounded) for data_valid; lat counts edges after the tick edge.
    task automatic run_frame(output int lat, output int out);
        bit got;
        got = 1'b0;
        lat = 0;
        @(negedge Clk);
        sample_clk = 1'b1;
        @(posedge Clk);
        for (int i = 1; i <= 60 && !got; i++) begin
            @(posedge Clk);
            #1;
            if (data_valid === 1'b1) begin
                got = 1'b1;
                lat = i;
            end
        end
        out = int'(data_out);
        @(negedge Clk);
        sample_clk = 1'b0;
    endtask

    initial begin
        int lat;
        int out;
        int dv0;

        Reset      = 1'b1;
        CS         = 1'b1;
        sample_clk = 1'b0;
        freq_in    = '0;
        note_on    = '0;
        repeat (3) @(negedge Clk);
        check("reset data_out",   int'(data_out), 0);
        check("reset data_valid", int'(data_valid), 0);
        check("reset sat_flag",   int'(sat_flag), 0);
        check("reset overrun",    int'(overrun), 0);
        Reset = 1'b0;
        @(negedge Clk);

        // Single-frame vectors, each from a fresh reset.
        vecs[0] = '{24'h400000, 24'h000000, 24'h000000, 24'h000000, 4'b0001,  28670, 1'b0};
        vecs[1] = '{24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b0010,  28670, 1'b0};
        vecs[2] = '{24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b1111,  32767, 1'b1};
        vecs[3] = '{24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b0000,      0, 1'b0};
        vecs[4] = '{24'hC00000, 24'h000000, 24'h000000, 24'h000000, 4'b0001, -28672, 1'b0};
        vecs[5] = '{24'h400000, 24'h000000, 24'hC00000, 24'h000000, 4'b0101,     -2, 1'b0};
        vecs[6] = '{24'hC00000, 24'hC00000, 24'hC00000, 24'hC00000, 4'b1111, -32768, 1'b1};
        vecs[7] = '{24'h000000, 24'h000000, 24'h000000, 24'h200000, 4'b1000,  32767, 1'b1};

        for (int i = 0; i < NVEC; i++) begin
            do_reset();
            set_voices(vecs[i].f0, vecs[i].f1, vecs[i].f2, vecs[i].f3, vecs[i].note);
            run_frame(lat, out);
            check($sformatf("vec%0d data_out", i), out, vecs[i].exp_out);
            check($sformatf("vec%0d latency", i), lat, LATENCY);
            check($sformatf("vec%0d sat_flag", i), int'(sat_flag), int'(vecs[i].exp_sat));
            check($sformatf("vec%0d overrun", i), int'(overrun), 0);
        end

        // Sticky sat_flag, then a reset mid-RUN that aborts the frame.
        do_reset();
        set_voices(24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b1111);
        run_frame(lat, out);
        check("clip data_out", out, 32767);
        set_voices(24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b0000);
        run_frame(lat, out);
        check("quiet after clip data_out", out, 0);
        check("sat_flag sticky", int'(sat_flag), 1);

        set_voices(24'h400000, 24'h400000, 24'h400000, 24'h400000, 4'b0001);
        @(negedge Clk);
        sample_clk = 1'b1;
        @(posedge Clk);
        dv0 = dv_count;
        repeat (10) @(posedge Clk);
        #1 Reset = 1'b1;
        #1;
        check("midrun reset data_out",   int'(data_out), 0);
        check("midrun reset data_valid", int'(data_valid), 0);
        check("midrun reset sat_flag",   int'(sat_flag), 0);
        check("midrun reset overrun",    int'(overrun), 0);
        repeat (3) @(negedge Clk);
        sample_clk = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        check("midrun reset no data_valid", dv_count - dv0, 0);
        run_frame(lat, out);
        check("after reset data_out", out, 28670);
        check("after reset latency", lat, LATENCY);

        // Phase advance, hold, note release and re-trigger.
        do_reset();
        set_voices(24'h400000, 24'h0, 24'h0, 24'h0, 4'b0001);
        run_frame(lat, out);
        check("seq frame1 data_out", out, 28670);
        repeat (10) @(negedge Clk);
        check("seq data_out holds", int'(data_out), 28670);
        run_frame(lat, out);
        check("seq frame2 data_out", out, 0);
        note_on = 4'b0000;
        run_frame(lat, out);
        check("seq frame3 data_out", out, 0);
        note_on = 4'b0001;
        run_frame(lat, out);
        check("seq retrigger data_out", out, 28670);

        // Phase wrap modulo 2^24.
        do_reset();
        set_voices(24'hC00000, 24'h0, 24'h0, 24'h0, 4'b0001);
        run_frame(lat, out);
        check("wrap frame1 data_out", out, -28672);
        run_frame(lat, out);
        check("wrap frame2 data_out", out, 0);

        // Second sample_clk edge 10 cycles into a frame.
        do_reset();
        set_voices(24'h400000, 24'h0, 24'h0, 24'h0, 4'b0001);
        dv0 = dv_count;
        @(negedge Clk);
        sample_clk = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        sample_clk = 1'b0;
        repeat (9) @(negedge Clk);
        sample_clk = 1'b1;
        @(negedge Clk);
        sample_clk = 1'b0;
        repeat (50) @(negedge Clk);
        check("overrun set", int'(overrun), 1);
        check("overrun single data_valid", dv_count - dv0, 1);
        check("overrun data_out", int'(data_out), 28670);

        // Ticks with CS low are dropped and leave the phases alone.
        do_reset();
        set_voices(24'h400000, 24'h0, 24'h0, 24'h0, 4'b0001);
        CS  = 1'b0;
        dv0 = dv_count;
        @(negedge Clk);
        sample_clk = 1'b1;
        @(negedge Clk);
        sample_clk = 1'b0;
        repeat (40) @(negedge Clk);
        check("cs low no data_valid", dv_count - dv0, 0);
        check("cs low overrun", int'(overrun), 0);
        CS = 1'b1;
        run_frame(lat, out);
        check("cs high data_out", out, 28670);
        check("cs high latency", lat, LATENCY);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
